seq_det_sched: RTL and testbench

Round-robin scheduler that shares one serial sequence detector (single-bit data_in, single-bit sout) between NREQ byte-wide requesters. It captures one byte per grant and serializes it MSB-first onto the detector input. It clears detector state whenever the stream owner changes. Each detector hit is attributed back to the requester whose bit caused it, and the block keeps a per-requester hit counter. It sits between the requester blocks and the detector instance.

---
 rtl/seq_det_pkg.sv | 17 +
 rtl/seq_det_ser.sv | 46 ++++
 rtl/seq_det_sched.sv | 184 ++++++++++++++++++
 tb/tb_seq_det_sched.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared types and constants for the sequence-detector scheduler.
// FSM state encoding, byte width and tag field widths.
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLR   = 2'd2,
        SHIFT = 2'd3
    } state_t;

    localparam int BYTE_W    = 8;
    localparam int BIT_CNT_W = 3;
    localparam int TAG_VLD_W = 1;
    localparam int TAG_OWN_W = 3;

endpackage

// File: rtl/seq_det_ser.sv
// seq_det_ser: 8-bit load/shift serializer, MSB first.
// ser_vld is high for exactly BYTE_W cycles after a load; last_bit flags the final one.
module seq_det_ser
    import seq_det_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [BYTE_W-1:0] din,
    output logic              ser_out,
    output logic              ser_vld,
    output logic              last_bit
);

    logic [BYTE_W-1:0]    shreg_p0;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic                 vld_p0;

    // Data shift register: take the new byte on load, shift left while a byte is in flight
    always_ff @(posedge clk) begin
        if (load)
            shreg_p0 <= din;
        else if (vld_p0)
            shreg_p0 <= {shreg_p0[BYTE_W-2:0], 1'b0};
    end

    // Control: valid flag and bit counter, valid drops after the eighth bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0  <= 1'b0;
            bit_cnt <= '0;
        end else if (load) begin
            vld_p0  <= 1'b1;
            bit_cnt <= '0;
        end else if (vld_p0) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (last_bit)
                vld_p0 <= 1'b0;
        end
    end

    assign ser_vld  = vld_p0;
    assign ser_out  = vld_p0 & shreg_p0[BYTE_W-1];
    assign last_bit = vld_p0 && (bit_cnt == BIT_CNT_W'(BYTE_W - 1));

endmodule

// File: rtl/seq_det_sched.sv
// seq_det_sched: round-robin scheduler sharing one serial sequence detector
// between NREQ byte-wide requesters, with per-requester hit attribution.
// Build option: define HIT_SAT_EN to make hit counters saturate instead of wrap.
module seq_det_sched
    import seq_det_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int DET_LAT = 1,
    parameter int CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*8-1:0]     byte_in,
    output logic [NREQ-1:0]       ack,
    output logic                  ser_out,
    output logic                  ser_vld,
    output logic                  det_clr,
    input  logic                  det_hit,
    input  logic                  cnt_clr,
    output logic [NREQ*CNT_W-1:0] hit_cnt,
    output logic                  stray_hit,
    output logic                  busy
);

    state_t               state;
    logic [TAG_OWN_W-1:0] ptr;
    logic [TAG_OWN_W-1:0] g;
    logic [TAG_OWN_W-1:0] g_sel;
    logic [TAG_OWN_W-1:0] idx;
    logic [TAG_OWN_W-1:0] last_owner;
    logic                 last_vld;
    logic                 any_req;
    logic                 same_owner;
    logic                 pipe_empty;
    logic                 ser_load;
    logic                 ser_last;
    logic [BYTE_W-1:0]    byte_sel;
    logic [BYTE_W-1:0]    byte_q;
    logic [BYTE_W-1:0]    ser_din;
    logic [DET_LAT-1:0]   tag_vld;
    logic [TAG_OWN_W-1:0] tag_own [DET_LAT];
    logic [CNT_W-1:0]     cnt     [NREQ];

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
`ifdef HIT_SAT_EN
        return (c == '1) ? c : c + 1'b1;
`else
        return c + 1'b1;
`endif
    endfunction

    // Round-robin search: lowest offset from ptr with req high wins
    always_comb begin
        any_req = 1'b0;
        g_sel   = '0;
        idx     = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i >= NREQ) ? TAG_OWN_W'(int'(ptr) + i - NREQ)
                                          : TAG_OWN_W'(int'(ptr) + i);
            if (req[idx]) begin
                any_req = 1'b1;
                g_sel   = idx;
            end
        end
    end

    assign byte_sel   = byte_in[BYTE_W*int'(g_sel) +: BYTE_W];
    assign same_owner = last_vld && (g_sel == last_owner);
    assign pipe_empty = ~|tag_vld;
    assign ser_load   = ((state == IDLE) && any_req && same_owner) || (state == CLR);
    assign ser_din    = (state == IDLE) ? byte_sel : byte_q;

    // Scheduler FSM: grant, drain old owner's tags, clear detector, shift the byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            g          <= '0;
            last_owner <= '0;
            last_vld   <= 1'b0;
            ack        <= '0;
            det_clr    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            ack     <= '0;
            det_clr <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        g          <= g_sel;
                        ack[g_sel] <= 1'b1;
                        ptr        <= (g_sel == TAG_OWN_W'(NREQ - 1)) ? '0 : g_sel + 1'b1;
                        busy       <= 1'b1;
                        if (same_owner) begin
                            state <= SHIFT;
                        end else if (pipe_empty) begin
                            state   <= CLR;
                            det_clr <= 1'b1;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pipe_empty) begin
                        state   <= CLR;
                        det_clr <= 1'b1;
                    end
                end
                CLR: begin
                    last_owner <= g;
                    last_vld   <= 1'b1;
                    state      <= SHIFT;
                end
                SHIFT: begin
                    if (ser_last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Granted byte holding register, used when the load is delayed by DRAIN/CLR
    always_ff @(posedge clk) begin
        if ((state == IDLE) && any_req)
            byte_q <= byte_sel;
    end

    seq_det_ser u_ser (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ser_load),
        .din      (ser_din),
        .ser_out  (ser_out),
        .ser_vld  (ser_vld),
        .last_bit (ser_last)
    );

    // Tag pipeline valid bits, aligned with the detector latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld <= '0;
        end else begin
            tag_vld[0] <= ser_vld;
            for (int k = 1; k < DET_LAT; k++)
                tag_vld[k] <= tag_vld[k-1];
        end
    end

    // Tag pipeline owner fields travel alongside the valid bits
    always_ff @(posedge clk) begin
        tag_own[0] <= g;
        for (int k = 1; k < DET_LAT; k++)
            tag_own[k] <= tag_own[k-1];
    end

    // Hit attribution: count to the tagged owner, flag hits without a valid tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NREQ; k++)
                cnt[k] <= '0;
            stray_hit <= 1'b0;
        end else begin
            if (det_hit && !tag_vld[DET_LAT-1])
                stray_hit <= 1'b1;
            for (int k = 0; k < NREQ; k++) begin
                if (cnt_clr)
                    cnt[k] <= '0;
                else if (det_hit && tag_vld[DET_LAT-1] &&
                         (tag_own[DET_LAT-1] == TAG_OWN_W'(k)))
                    cnt[k] <= cnt_inc(cnt[k]);
            end
        end
    end

    for (genvar k = 0; k < NREQ; k++) begin : g_cnt_out
        assign hit_cnt[CNT_W*k +: CNT_W] = cnt[k];
    end

endmodule

// File: tb/tb_seq_det_sched.sv
// tb_seq_det_sched: directed and randomized checks of seq_det_sched against a
// transaction-level model (round-robin order, popcount hit totals, byte spacing).
module tb_seq_det_sched;

    localparam int NREQ    = 3;
    localparam int DET_LAT = 3;
    localparam int CNT_W   = 4;
    localparam int MAXC    = (1 << CNT_W) - 1;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*8-1:0]     byte_in = '0;
    logic [NREQ-1:0]       ack;
    logic                  ser_out;
    logic                  ser_vld;
    logic                  det_clr;
    logic                  det_hit;
    logic                  cnt_clr = 1'b0;
    logic [NREQ*CNT_W-1:0] hit_cnt;
    logic                  stray_hit;
    logic                  busy;

    seq_det_sched #(.NREQ(NREQ), .DET_LAT(DET_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .byte_in(byte_in), .ack(ack),
        .ser_out(ser_out), .ser_vld(ser_vld), .det_clr(det_clr), .det_hit(det_hit),
        .cnt_clr(cnt_clr), .hit_cnt(hit_cnt), .stray_hit(stray_hit), .busy(busy)
    );

    always #5 clk = ~clk;

    // Detector stand-in: hit equals the serial bit DET_LAT cycles earlier
    logic [DET_LAT-1:0] hist = '0;
    logic               det_force = 1'b0;
    always @(posedge clk) hist <= {hist[DET_LAT-2:0], ser_out};
    assign det_hit = det_force | hist[DET_LAT-1];

    // Monitor: grants, serialized bytes, byte start cycles, det_clr pulses
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int grant_q[$];
    int ack_cyc_q[$];
    int byte_q[$];
    int start_q[$];
    int clr_n = 0;
    logic [7:0] sh = '0;
    int nb = 0;
    always @(negedge clk) begin
        if (!rst_n) nb = 0;
        for (int k = 0; k < NREQ; k++)
            if (ack[k]) begin
                grant_q.push_back(k);
                ack_cyc_q.push_back(cyc);
            end
        if (det_clr) clr_n++;
        if (ser_vld) begin
            if (nb == 0) start_q.push_back(cyc);
            sh = {sh[6:0], ser_out};
            nb++;
            if (nb == 8) begin
                byte_q.push_back(int'(sh));
                nb = 0;
            end
        end
    end

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
        end
    endtask

    // Reference model state
    int   exp_ptr;
    int   exp_last;
    int   exp_cnt[NREQ];
    logic exp_stray;
    int   bn[NREQ];
    logic [7:0] bmem[NREQ][32];

    function automatic int upd(input int c, input int n);
`ifdef HIT_SAT_EN
        return (c + n > MAXC) ? MAXC : c + n;
`else
        return (c + n) % (1 << CNT_W);
`endif
    endfunction

    function automatic int get_cnt(input int k);
        return int'(hit_cnt[CNT_W*k +: CNT_W]);
    endfunction

    task automatic model_reset();
        exp_ptr   = 0;
        exp_last  = -1;
        exp_stray = 1'b0;
        for (int k = 0; k < NREQ; k++) exp_cnt[k] = 0;
    endtask

    task automatic model_grant(input int g, input logic [7:0] b);
        exp_ptr    = (g + 1) % NREQ;
        exp_last   = g;
        exp_cnt[g] = upd(exp_cnt[g], $countones(b));
    endtask

    task automatic check_counts(input string nm);
        for (int k = 0; k < NREQ; k++)
            chk($sformatf("%s_cnt%0d", nm, k), get_cnt(k), exp_cnt[k]);
        chk({nm, "_stray"}, stray_hit, exp_stray);
    endtask

    task automatic clear_queues();
        for (int k = 0; k < NREQ; k++) bn[k] = 0;
    endtask

    // Serve all per-requester byte lists; requesters re-raise with the next byte after each ack
    task automatic serve(input string nm);
        int eg[$];
        int eb[$];
        int egap[$];
        int left[NREQ];
        int sent[NREQ];
        int total, g, c, eclr, lat, budget;
        int g0, b0, s0, c0;
        total = 0; eclr = 0; lat = 0;
        for (int k = 0; k < NREQ; k++) begin
            left[k] = bn[k];
            sent[k] = 0;
            total += bn[k];
        end
        while (total > 0) begin
            g = -1;
            for (int i = 0; i < NREQ; i++) begin
                c = (exp_ptr + i) % NREQ;
                if (g < 0 && left[c] > 0) g = c;
            end
            eg.push_back(g);
            eb.push_back(int'(bmem[g][bn[g] - left[g]]));
            if (eg.size() == 1) lat = (g == exp_last) ? 0 : 1;
            else egap.push_back((g == exp_last) ? 9 : 10 + DET_LAT);
            if (g != exp_last) eclr++;
            model_grant(g, bmem[g][bn[g] - left[g]]);
            left[g]--;
            total--;
        end

        g0 = grant_q.size(); b0 = byte_q.size(); s0 = start_q.size(); c0 = clr_n;
        for (int k = 0; k < NREQ; k++) begin
            req[k] = (bn[k] > 0);
            byte_in[8*k +: 8] = bmem[k][0];
        end
        budget = 0;
        while ((req != '0 || busy) && budget < 2000) begin
            @(posedge clk); #1;
            budget++;
            for (int k = 0; k < NREQ; k++)
                if (ack[k] && req[k]) begin
                    sent[k]++;
                    if (sent[k] < bn[k]) byte_in[8*k +: 8] = bmem[k][sent[k]];
                    else req[k] = 1'b0;
                end
        end
        chk({nm, "_done"}, budget < 2000, 1);
        req = '0;
        repeat (DET_LAT + 3) @(posedge clk);
        #1;

        chk({nm, "_ngrant"}, grant_q.size() - g0, eg.size());
        if (grant_q.size() - g0 == eg.size())
            for (int i = 0; i < eg.size(); i++)
                chk($sformatf("%s_grant%0d", nm, i), grant_q[g0+i], eg[i]);
        chk({nm, "_nbyte"}, byte_q.size() - b0, eb.size());
        if (byte_q.size() - b0 == eb.size())
            for (int i = 0; i < eb.size(); i++)
                chk($sformatf("%s_byte%0d", nm, i), byte_q[b0+i], eb[i]);
        if (start_q.size() - s0 == eg.size() && grant_q.size() - g0 == eg.size() && eg.size() > 0) begin
            chk({nm, "_lat"}, start_q[s0] - ack_cyc_q[g0], lat);
            for (int i = 1; i < eg.size(); i++)
                chk($sformatf("%s_gap%0d", nm, i), start_q[s0+i] - start_q[s0+i-1], egap[i-1]);
        end
        chk({nm, "_clr"}, clr_n - c0, eclr);
        chk({nm, "_busy"}, busy, 0);
        check_counts(nm);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0; cnt_clr = 1'b0; det_force = 1'b0;
        model_reset();
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    int budget;

    initial begin
        // Reset values while reset is held
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_ack", ack, 0);
        chk("rst_ser_out", ser_out, 0);
        chk("rst_ser_vld", ser_vld, 0);
        chk("rst_det_clr", det_clr, 0);
        chk("rst_hit_cnt", hit_cnt, 0);
        chk("rst_stray", stray_hit, 0);
        chk("rst_busy", busy, 0);
        do_reset();

        // Single byte B4 from requester 0
        clear_queues();
        bn[0] = 1; bmem[0][0] = 8'hB4;
        serve("b4");

        // Both requesters together: FF from 0, 01 from 1
        do_reset();
        clear_queues();
        bn[0] = 1; bmem[0][0] = 8'hFF;
        bn[1] = 1; bmem[1][0] = 8'h01;
        serve("pair");

        // Three back-to-back bytes from requester 1
        do_reset();
        clear_queues();
        bn[1] = 3;
        for (int i = 0; i < 3; i++) bmem[1][i] = 8'($urandom);
        serve("burst1");

        // Randomized mixes over all requesters
        for (int t = 0; t < 6; t++) begin
            int sum;
            clear_queues();
            sum = 0;
            for (int k = 0; k < NREQ; k++) begin
                bn[k] = $urandom_range(0, 2);
                sum += bn[k];
                for (int i = 0; i < bn[k]; i++) bmem[k][i] = 8'($urandom);
            end
            if (sum == 0) begin
                bn[t % NREQ] = 1;
                bmem[t % NREQ][0] = 8'($urandom);
            end
            serve($sformatf("rnd%0d", t));
            if ($urandom_range(0, 2) == 0) begin
                cnt_clr = 1'b1;
                @(posedge clk); #1;
                cnt_clr = 1'b0;
                for (int k = 0; k < NREQ; k++) exp_cnt[k] = 0;
                check_counts($sformatf("idleclr%0d", t));
            end
        end

        // Counter overflow: 20 bytes of FF
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        for (int k = 0; k < NREQ; k++) exp_cnt[k] = 0;
        clear_queues();
        bn[0] = 20;
        for (int i = 0; i < 20; i++) bmem[0][i] = 8'hFF;
        serve("ovf");

        // cnt_clr coincident with the only hit of byte 01
        req = '0;
        byte_in[7:0] = 8'h01;
        req[0] = 1'b1;
        budget = 0;
        while (!ack[0] && budget < 50) begin @(posedge clk); #1; budget++; end
        chk("clrhit_ack", ack[0], 1);
        req[0] = 1'b0;
        model_grant(0, 8'h01);
        budget = 0;
        while (!det_hit && budget < 60) begin @(posedge clk); #1; budget++; end
        chk("clrhit_seen", det_hit, 1);
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        for (int k = 0; k < NREQ; k++) exp_cnt[k] = 0;
        repeat (DET_LAT + 3) @(posedge clk);
        #1;
        check_counts("clrhit");

        // Stray hit while idle, sticky through later traffic
        det_force = 1'b1;
        @(posedge clk); #1;
        det_force = 1'b0;
        exp_stray = 1'b1;
        check_counts("stray");
        clear_queues();
        bn[2] = 1; bmem[2][0] = 8'h5A;
        serve("stray_keep");

        // Reset in the middle of a shift
        req[1] = 1'b1;
        byte_in[15:8] = 8'hFF;
        budget = 0;
        while (!ack[1] && budget < 50) begin @(posedge clk); #1; budget++; end
        chk("midrst_ack", ack[1], 1);
        req[1] = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_vld", ser_vld, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_cnt", hit_cnt, 0);
        chk("midrst_stray", stray_hit, 0);
        do_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_noack", ack, 0);
        chk("midrst_idle_busy", busy, 0);
        clear_queues();
        bn[1] = 1; bmem[1][0] = 8'h0F;
        bn[2] = 1; bmem[2][0] = 8'hC3;
        serve("after_rst");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
